// File: rtl/mips_pkg.sv
// Shared types for the MIPS load/store unit: access size, load mode,
// response cause, FSM state and the captured request record.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_LWL    = 2'd1,
    MODE_LWR    = 2'd2
  } lsmode_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } cause_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_LAT  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Request fields that must outlive the request cycle.
  typedef struct packed {
    logic        write;
    size_t       size;
    logic        sgn;
    lsmode_t     mode;
    logic [1:0]  k;
    logic [31:0] rt_old;
  } req_t;

  // HALF needs an even address; a plain WORD needs a word address.
  // LWL/LWR exist precisely to handle unaligned words, and stores ignore mode.
  function automatic logic is_misaligned(input logic write, input size_t size,
                                         input lsmode_t mode, input logic [1:0] k);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF && k[0]) mis = 1'b1;
    if (size == SZ_WORD && (write || mode == MODE_NORMAL) && k != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/mips_lsu_lane_align.sv
// Little-endian byte-lane steering: store data/byteenable replication and
// load extract, extend and LWL/LWR merge. Purely combinational.
module mips_lsu_lane_align
  import mips_pkg::*;
(
  input  logic        write,
  input  size_t       size,
  input  logic        sgn,
  input  lsmode_t     mode,
  input  logic [1:0]  k,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] wdata_lane,
  output logic [3:0]  be,
  output logic [31:0] rdata_out
);

  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // 8*k and 8*(3-k); for a 2-bit k, 3-k is simply ~k.
  assign sh_r     = {k, 3'b000};
  assign sh_l     = {~k, 3'b000};
  assign byte_sel = rdata[sh_r +: 8];
  assign half_sel = k[1] ? rdata[31:16] : rdata[15:0];

  // Lane steering for stores, extraction/merge for loads.
  always_comb begin
    wdata_lane = wdata;
    be         = 4'b1111;
    rdata_out  = rdata;
    if (write) begin
      case (size)
        SZ_BYTE: begin
          be         = 4'b0001 << k;
          wdata_lane = {4{wdata[7:0]}};
        end
        SZ_HALF: begin
          be         = k[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end else begin
      case (mode)
        MODE_LWL: rdata_out = (rdata << sh_l) | (rt_old & ~(32'hFFFF_FFFF << sh_l));
        MODE_LWR: rdata_out = (rdata >> sh_r) | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
        default: begin
          case (size)
            SZ_BYTE: rdata_out = {{24{sgn & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_out = {{16{sgn & half_sel[15]}}, half_sel};
            default: rdata_out = rdata;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_lsu_bus.sv
// Load/store unit between the MIPS core and an Avalon-MM master port.
// One request in flight; registered bus and response outputs.
//
// state   | meaning
// IDLE    | ready for a request
// BUS     | read/write asserted, waiting for waitrequest=0 or timeout
// LAT     | load accepted, counting read latency before sampling readdata
// RESP    | resp_valid pulse
module mips_lsu_bus
  import mips_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_cause,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              read,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam logic [1:0]  LAT_INIT = 2'(READ_LATENCY - 1);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  req_t              req_live, lane_req;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [31:0]       writedata_q, writedata_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  cause_t            resp_cause_q, resp_cause_d;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_be;
  logic [31:0]       lane_rdata;

  // Live request fields; the lane logic sees these in IDLE (store steering)
  // and the captured copy afterwards (load extract/merge).
  always_comb begin
    req_live.write  = req_write;
    req_live.size   = size_t'(req_size);
    req_live.sgn    = req_signed;
    req_live.mode   = lsmode_t'(req_mode);
    req_live.k      = req_addr[1:0];
    req_live.rt_old = req_rt_old;
    lane_req        = (state_q == ST_IDLE) ? req_live : req_q;
  end

  mips_lsu_lane_align u_lane (
    .write      (lane_req.write),
    .size       (lane_req.size),
    .sgn        (lane_req.sgn),
    .mode       (lane_req.mode),
    .k          (lane_req.k),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .rt_old     (lane_req.rt_old),
    .wdata_lane (lane_wdata),
    .be         (lane_be),
    .rdata_out  (lane_rdata)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    lat_cnt_d    = lat_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_cause_d = resp_cause_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = req_live;
          if (is_misaligned(req_live.write, req_live.size, req_live.mode, req_live.k)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_cause_d = CAUSE_MISALIGN;
          end else begin
            state_d      = ST_BUS;
            address_d    = {req_addr[ADDR_W-1:2], 2'b00};
            read_d       = ~req_write;
            write_d      = req_write;
            writedata_d  = lane_wdata;
            byteenable_d = lane_be;
            wait_cnt_d   = '0;
          end
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (req_q.write) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_cause_d = CAUSE_NONE;
          end else begin
            state_d   = ST_LAT;
            lat_cnt_d = LAT_INIT;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          if (TIMEOUT != 0 && wait_cnt_d == TO_LIMIT) begin
            read_d       = 1'b0;
            write_d      = 1'b0;
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_LAT: begin
        if (lat_cnt_q == 2'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = lane_rdata;
          resp_cause_d = CAUSE_NONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops the bus strobes immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      lat_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      lat_cnt_q    <= lat_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_cause = resp_cause_q;

endmodule

// File: tb/tb_mips_lsu_bus.sv
// Directed bench for mips_lsu_bus with READ_LATENCY=2, TIMEOUT=4.
module tb_mips_lsu_bus;

  localparam int RL = 2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [1:0]  req_mode = 2'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_rt_old = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  mips_lsu_bus #(.ADDR_W(32), .READ_LATENCY(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_cause(resp_cause),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents the request for one edge and returns at the next negedge.
  task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [1:0] md,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rt);
    t0 = cyc;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_mode = md;
    req_addr = a; req_wdata = wd; req_rt_old = rt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for resp_valid and checks edges since the request edge.
  task automatic wait_resp(input string tag, input int exp_lat);
    while (!resp_valid && (cyc - t0) < 40) @(negedge clk);
    chk({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
  endtask

  // Checks response content, then that the pulse lasts one cycle.
  task automatic chk_resp(input string tag, input logic [31:0] rd, input logic [1:0] cause);
    chk({tag, "_rdata"}, resp_rdata, rd);
    chk({tag, "_cause"}, {30'd0, resp_cause}, {30'd0, cause});
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_be", {28'd0, byteenable}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // SB to byte 3
    send(1'b1, 2'd0, 1'b0, 2'd0, 32'h1003, 32'h0000_00AB, 32'h0);
    chk("sb_address", address, 32'h1000);
    chk("sb_write", {31'd0, write}, 32'd1);
    chk("sb_read", {31'd0, read}, 32'd0);
    chk("sb_be", {28'd0, byteenable}, 32'h8);
    chk("sb_wdata", writedata, 32'hABAB_ABAB);
    wait_resp("sb", 2);
    chk("sb_write_drop", {31'd0, write}, 32'd0);
    chk_resp("sb", 32'h0, 2'd0);

    // SH to upper half, SW
    send(1'b1, 2'd1, 1'b0, 2'd0, 32'h6002, 32'hFFFF_1234, 32'h0);
    chk("sh_be", {28'd0, byteenable}, 32'hC);
    chk("sh_wdata", writedata, 32'h1234_1234);
    chk("sh_address", address, 32'h6000);
    wait_resp("sh", 2);
    chk_resp("sh", 32'h0, 2'd0);
    send(1'b1, 2'd2, 1'b0, 2'd0, 32'h7004, 32'hDEAD_BEEF, 32'h0);
    chk("sw_be", {28'd0, byteenable}, 32'hF);
    chk("sw_wdata", writedata, 32'hDEAD_BEEF);
    wait_resp("sw", 2);
    chk_resp("sw", 32'h0, 2'd0);

    // LB / LBU byte 1
    readdata = 32'h0000_F100;
    send(1'b0, 2'd0, 1'b1, 2'd0, 32'h2001, 32'h0, 32'h0);
    chk("lb_read", {31'd0, read}, 32'd1);
    chk("lb_be", {28'd0, byteenable}, 32'hF);
    chk("lb_address", address, 32'h2000);
    wait_resp("lb", 2 + RL);
    chk_resp("lb", 32'hFFFF_FFF1, 2'd0);
    send(1'b0, 2'd0, 1'b0, 2'd0, 32'h2001, 32'h0, 32'h0);
    wait_resp("lbu", 2 + RL);
    chk_resp("lbu", 32'h0000_00F1, 2'd0);

    // LH / LHU upper half
    readdata = 32'h8001_7F00;
    send(1'b0, 2'd1, 1'b1, 2'd0, 32'h2002, 32'h0, 32'h0);
    wait_resp("lh", 2 + RL);
    chk_resp("lh", 32'hFFFF_8001, 2'd0);
    send(1'b0, 2'd1, 1'b0, 2'd0, 32'h2000, 32'h0, 32'h0);
    wait_resp("lhu", 2 + RL);
    chk_resp("lhu", 32'h0000_7F00, 2'd0);

    // LW with three wait cycles
    readdata = 32'h1234_5678;
    waitrequest = 1'b1;
    send(1'b0, 2'd2, 1'b0, 2'd0, 32'h4008, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lw_wait_read%0d", i), {31'd0, read}, 32'd1);
      chk($sformatf("lw_wait_addr%0d", i), address, 32'h4008);
      if (i < 3) @(negedge clk);
    end
    waitrequest = 1'b0;
    @(negedge clk);
    chk("lw_read_drop", {31'd0, read}, 32'd0);
    wait_resp("lw", 5 + RL);
    chk_resp("lw", 32'h1234_5678, 2'd0);

    // LWL / LWR with k=1
    readdata = 32'h4433_2211;
    send(1'b0, 2'd2, 1'b0, 2'd1, 32'h5001, 32'h0, 32'hAABB_CCDD);
    chk("lwl_address", address, 32'h5000);
    wait_resp("lwl", 2 + RL);
    chk_resp("lwl", 32'h2211_CCDD, 2'd0);
    send(1'b0, 2'd2, 1'b0, 2'd2, 32'h5001, 32'h0, 32'hAABB_CCDD);
    wait_resp("lwr", 2 + RL);
    chk_resp("lwr", 32'hAA44_3322, 2'd0);

    // Misaligned LH and SW (mode ignored for stores)
    send(1'b0, 2'd1, 1'b1, 2'd0, 32'h3001, 32'h0, 32'h0);
    chk("mis_lh_read", {31'd0, read}, 32'd0);
    wait_resp("mis_lh", 1);
    chk_resp("mis_lh", 32'h0, 2'd1);
    send(1'b1, 2'd2, 1'b0, 2'd1, 32'h7002, 32'h1, 32'h0);
    chk("mis_sw_write", {31'd0, write}, 32'd0);
    wait_resp("mis_sw", 1);
    chk_resp("mis_sw", 32'h0, 2'd1);

    // Timeout with waitrequest stuck high
    readdata = 32'hFFFF_FFFF;
    waitrequest = 1'b1;
    send(1'b0, 2'd2, 1'b0, 2'd0, 32'h8000, 32'h0, 32'h0);
    for (int i = 0; i < TO; i++) begin
      chk($sformatf("to_read%0d", i), {31'd0, read}, 32'd1);
      if (i < TO - 1) @(negedge clk);
    end
    @(negedge clk);
    chk("to_read_drop", {31'd0, read}, 32'd0);
    wait_resp("to", TO + 1);
    chk_resp("to", 32'h0, 2'd2);

    // Reset in the middle of BUS
    send(1'b0, 2'd2, 1'b0, 2'd0, 32'h9000, 32'h0, 32'h0);
    chk("mid_read_pre", {31'd0, read}, 32'd1);
    chk("mid_ready_pre", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_read_async", {31'd0, read}, 32'd0);
    chk("mid_addr_async", address, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0;
    @(negedge clk);
    chk("mid_ready_post", {31'd0, req_ready}, 32'd1);
    chk("mid_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("mid_read_post", {31'd0, read}, 32'd0);

    // Normal operation after reset
    send(1'b1, 2'd0, 1'b0, 2'd0, 32'hA000, 32'h0000_005A, 32'h0);
    chk("post_be", {28'd0, byteenable}, 32'h1);
    chk("post_wdata", writedata, 32'h5A5A_5A5A);
    wait_resp("post", 2);
    chk_resp("post", 32'h0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_lsu_bus.md
Name: mips_lsu_bus

Overview:
Parametrised load/store unit sitting between the MIPS core datapath and the Avalon memory-mapped bus.
- Accepts one memory request at a time from the core.
- Runs the Avalon transaction, honouring waitrequest.
- Performs little-endian byte-lane steering for SB/SH/SW and LB/LBU/LH/LHU/LW/LWL/LWR.
- Returns the aligned, extended or merged result to the core.
- Adds configurable read latency, misalignment detection and a bus-timeout error.

Parameters:
- ADDR_W, 32, width of req_addr and address.
- READ_LATENCY, 1, cycles from read acceptance edge to readdata valid; legal 1..4.
- TIMEOUT, 0, max consecutive waitrequest-high cycles before abort; 0 disables.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  core request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  mips_pkg::size_t: BYTE=0, HALF=1, WORD=2
- req_signed  in  1  sign-extend LB/LH
- req_mode  in  2  mips_pkg::lsmode_t: NORMAL=0, LWL=1, LWR=2
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, low bits significant
- req_rt_old  in  32  current rt value, used for LWL/LWR merge
- resp_valid  out  1  one-cycle pulse, response valid
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_cause  out  2  mips_pkg::cause_t: NONE=0, MISALIGN=1, TIMEOUT=2
- address  out  ADDR_W  word-aligned bus address
- write  out  1  Avalon write
- read  out  1  Avalon read
- waitrequest  in  1  slave stall
- writedata  out  32  lane-steered store data
- byteenable  out  4  active byte lanes
- readdata  in  32  bus read data

Behaviour:
Reset and outputs
- On reset=0, asynchronously: state=IDLE, read=write=0, resp_valid=0, resp_rdata=0, resp_cause=NONE, address=0, writedata=0, byteenable=0, timeout counter=0.
- All bus and response outputs are registered.
- req_ready = (state==IDLE).

FSM: IDLE, BUS, LAT, RESP
- IDLE: on req_valid, capture the request.
  - Misaligned access (HALF with addr[0]=1, or WORD NORMAL with addr[1:0]!=0) goes to RESP with MISALIGN. No bus cycle is issued.
  - Otherwise go to BUS, driving address = {addr[ADDR_W-1:2],2'b00} and read or write.
- BUS: hold address, read, write, writedata and byteenable stable while waitrequest=1.
  - The edge with waitrequest=0 accepts the transfer and deasserts read/write.
  - An accepted store goes to RESP.
  - An accepted load goes to LAT.
- LAT: count READ_LATENCY edges after acceptance, sample readdata at the last one, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request is accepted in the following IDLE cycle.
- Latency, store with no wait: request edge → BUS one cycle → resp_valid in the 3rd cycle.
- Latency, load: 3+READ_LATENCY cycles.

Timeout
- In BUS, the counter increments on each edge with waitrequest=1.
- When TIMEOUT!=0 and the count reaches TIMEOUT: deassert read/write, go to RESP with cause TIMEOUT, resp_rdata=0.
- The counter clears on entering BUS.

Lane rules, k=addr[1:0]
- SB: byteenable=1<<k, writedata={4{wdata[7:0]}}.
- SH: byteenable=0011 (k=0) or 1100 (k=2), writedata={2{wdata[15:0]}}.
- SW: byteenable=1111.
- Loads: byteenable=1111.
- LB/LBU: byte k, sign- or zero-extended per req_signed.
- LH/LHU: half k[1], sign- or zero-extended per req_signed.
- LW: readdata unchanged.
- LWL: (readdata << 8*(3-k)) | (rt_old & ((1<<8*(3-k))-1)).
- LWR: (readdata >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k)).
- LWL/LWR are never misaligned. req_mode is ignored for stores.

Boundary conditions
- req_valid while not IDLE is ignored; the core must hold the request.
- reset=0 mid-BUS drops read/write immediately and asynchronously; no response is produced.
- waitrequest is ignored outside BUS.

Decomposition:
- mips_pkg holds size_t, lsmode_t, cause_t and the FSM state_t enum.
- One combinational sub-module, mips_lsu_lane_align, holds the store lane steering and load extract/extend/merge.
- FSM, registers and timeout counter remain in mips_lsu_bus.

Test Plan:
1. SB addr=0x1003, wdata=0xAB, waitrequest=0 → address=0x1000, byteenable=1000, writedata=0xABABABAB; resp_valid 2 cycles after request, cause=NONE.
2. LB addr=0x2001, signed, readdata=0x0000F100 → resp_rdata=0xFFFFFFF1. Same with LBU → 0x000000F1.
3. LW with waitrequest high 3 cycles and READ_LATENCY=2 → address/read stable all 3 cycles; resp_valid 7 cycles after request; data matches readdata.
4. LWL addr k=1, readdata=0x44332211, rt_old=0xAABBCCDD → 0x2211CCDD. LWR k=1 → 0xAA443322.
5. LH addr=0x3001 → no read issued; resp_valid with cause=MISALIGN, resp_rdata=0.
6. TIMEOUT=4, waitrequest stuck at 1 → read drops after 4 edges, cause=TIMEOUT. Then reset=0 mid-BUS in a second run → read=0 immediately, req_ready=1 after release.
